vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 143 ++++++++++++++
 tb/tb_vga_sync_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator.
//
// A clock divider produces a one-clk pix_en strobe every CLK_DIV clocks. On
// each strobe the pixel/line counters advance, and rgb, hsync, vsync and
// video_on are registered from the pre-advance counter position. The
// registered outputs therefore trail VGAx/VGAy by exactly one pixel period.
// A frame counter raises frame_tick once every FRAMES_PER_GEN frames, on the
// last pixel of the frame, so the board update happens during blanking.
//
// Ports:
//   clk        system clock, rising edge active
//   clr        asynchronous active-low reset
//   rgb_in     [2:0] colour for the current (VGAx, VGAy)
//   VGAx       [9:0] horizontal pixel counter, 0..H_TOTAL-1
//   VGAy       [9:0] line counter, 0..V_TOTAL-1
//   hsync      horizontal sync, active-low (registered)
//   vsync      vertical sync, active-low (registered)
//   rgb        [2:0] colour to the monitor, blanked to 0 outside the visible area
//   video_on   high while the pixel on rgb is visible (registered)
//   pix_en     one-clk strobe per pixel period
//   frame_tick one-clk strobe requesting a board generation update
module vga_sync_gen #(
  parameter int H_VISIBLE      = 640,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_VISIBLE      = 480,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter int CLK_DIV        = 2,
  parameter int FRAMES_PER_GEN = 30
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [2:0] rgb_in,
  output logic [9:0] VGAx,
  output logic [9:0] VGAy,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb,
  output logic       video_on,
  output logic       pix_en,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int                FRM_W    = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
  localparam logic [FRM_W-1:0]  FRM_LAST = FRM_W'(FRAMES_PER_GEN - 1);

  // Half-open window test lo <= v < hi.
  function automatic logic in_window(input logic [9:0] v, input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  logic             run_p0;
  logic [DIV_W-1:0] div_p0;
  logic [9:0]       x_p0;
  logic [9:0]       y_p0;
  logic [FRM_W-1:0] frame_p0;
  logic             line_end;
  logic             frame_end;
  logic             visible;

  logic [2:0]       rgb_p1;
  logic             hsync_p1;
  logic             vsync_p1;
  logic             video_on_p1;

  // run_p0 holds the divider idle for the first clock after reset release, so
  // the first strobe lands CLK_DIV clocks later and pix_en stays low in reset
  // even when CLK_DIV is 1.
  assign pix_en    = run_p0 && (div_p0 == DIV_LAST);
  assign line_end  = (x_p0 == H_LAST);
  assign frame_end = line_end && (y_p0 == V_LAST);
  assign visible   = (x_p0 < H_VIS) && (y_p0 < V_VIS);
  // Asserted on the strobe clock that wraps the frame counter.
  assign frame_tick = pix_en && frame_end && (frame_p0 == FRM_LAST);

  // ---- stage p0: pixel divider, raster and frame counters ----
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      run_p0   <= 1'b0;
      div_p0   <= '0;
      x_p0     <= '0;
      y_p0     <= '0;
      frame_p0 <= '0;
    end else begin
      run_p0 <= 1'b1;
      if (run_p0) begin
        div_p0 <= (div_p0 == DIV_LAST) ? '0 : div_p0 + 1'b1;
      end
      if (pix_en) begin
        if (line_end) begin
          x_p0 <= '0;
          y_p0 <= (y_p0 == V_LAST) ? '0 : y_p0 + 1'b1;
        end else begin
          x_p0 <= x_p0 + 1'b1;
        end
        if (frame_end) begin
          frame_p0 <= (frame_p0 == FRM_LAST) ? '0 : frame_p0 + 1'b1;
        end
      end
    end
  end

  // ---- stage p1: monitor outputs, one pixel behind the counters ----
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rgb_p1      <= 3'b000;
      hsync_p1    <= 1'b1;
      vsync_p1    <= 1'b1;
      video_on_p1 <= 1'b0;
    end else if (pix_en) begin
      rgb_p1      <= visible ? rgb_in : 3'b000;
      hsync_p1    <= !in_window(x_p0, H_SYNC_START, H_SYNC_END);
      vsync_p1    <= !in_window(y_p0, V_SYNC_START, V_SYNC_END);
      video_on_p1 <= visible;
    end
  end

  assign VGAx     = x_p0;
  assign VGAy     = y_p0;
  assign rgb      = rgb_p1;
  assign hsync    = hsync_p1;
  assign vsync    = vsync_p1;
  assign video_on = video_on_p1;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: drives three generator instances from one clock/reset
// (default timing; reduced raster with CLK_DIV=3 and FRAMES_PER_GEN=3;
// reduced raster with CLK_DIV=1) with random rgb_in, and compares every
// output after each clock edge with a closed-form raster model: the pixel
// index is derived from the number of edges since reset release, and x/y,
// sync windows, blanking and frame ticks follow from that index arithmetically.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       clr;
  logic [2:0] rgb_in;

  logic [9:0] vx   [3];
  logic [9:0] vy   [3];
  logic       hs   [3];
  logic       vs   [3];
  logic [2:0] rgbo [3];
  logic       von  [3];
  logic       pe   [3];
  logic       ft   [3];

  int vectors     = 0;
  int miscompares = 0;
  int k;
  int tick_cnt;
  int hs_low_cnt;
  logic [2:0] last_rgb [3];

  int dv [3], ht [3], vt [3], hv [3], vv [3];
  int hs0 [3], hs1 [3], vs0 [3], vs1 [3], fpg [3];

  always #5 clk = ~clk;

  vga_sync_gen u_def (
    .clk(clk), .clr(clr), .rgb_in(rgb_in),
    .VGAx(vx[0]), .VGAy(vy[0]), .hsync(hs[0]), .vsync(vs[0]),
    .rgb(rgbo[0]), .video_on(von[0]), .pix_en(pe[0]), .frame_tick(ft[0])
  );

  vga_sync_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(3), .FRAMES_PER_GEN(3)
  ) u_sm (
    .clk(clk), .clr(clr), .rgb_in(rgb_in),
    .VGAx(vx[1]), .VGAy(vy[1]), .hsync(hs[1]), .vsync(vs[1]),
    .rgb(rgbo[1]), .video_on(von[1]), .pix_en(pe[1]), .frame_tick(ft[1])
  );

  vga_sync_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(1), .FRAMES_PER_GEN(1)
  ) u_d1 (
    .clk(clk), .clr(clr), .rgb_in(rgb_in),
    .VGAx(vx[2]), .VGAy(vy[2]), .hsync(hs[2]), .vsync(vs[2]),
    .rgb(rgbo[2]), .video_on(von[2]), .pix_en(pe[2]), .frame_tick(ft[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_u%0d_pix_en", tag, i), 32'(pe[i]), 32'd0);
      chk($sformatf("%s_u%0d_VGAx", tag, i), 32'(vx[i]), 32'd0);
      chk($sformatf("%s_u%0d_VGAy", tag, i), 32'(vy[i]), 32'd0);
      chk($sformatf("%s_u%0d_rgb", tag, i), 32'(rgbo[i]), 32'd0);
      chk($sformatf("%s_u%0d_hsync", tag, i), 32'(hs[i]), 32'd1);
      chk($sformatf("%s_u%0d_vsync", tag, i), 32'(vs[i]), 32'd1);
      chk($sformatf("%s_u%0d_video_on", tag, i), 32'(von[i]), 32'd0);
      chk($sformatf("%s_u%0d_frame_tick", tag, i), 32'(ft[i]), 32'd0);
    end
  endtask

  // Expected state after the k-th rising edge since reset release.
  task automatic model_check(input int i);
    int n, cx, cy, q, hx, hy;
    logic pen, vis, hs_e, vs_e, von_e, ft_e;
    logic [2:0] rgb_e;
    // Strobe high after edges D, 2D, ...; sampled by the following edge.
    if (k >= 2 && (k - 1) % dv[i] == 0) last_rgb[i] = rgb_in;
    n   = (k >= 1) ? (k - 1) / dv[i] : 0;
    pen = (k >= 1) && (k % dv[i] == 0);
    cx  = n % ht[i];
    cy  = (n / ht[i]) % vt[i];
    if (n == 0) begin
      rgb_e = 3'b000; hs_e = 1'b1; vs_e = 1'b1; von_e = 1'b0;
    end else begin
      q     = n - 1;
      hx    = q % ht[i];
      hy    = (q / ht[i]) % vt[i];
      vis   = (hx < hv[i]) && (hy < vv[i]);
      von_e = vis;
      rgb_e = vis ? last_rgb[i] : 3'b000;
      hs_e  = !(hx >= hs0[i] && hx < hs1[i]);
      vs_e  = !(hy >= vs0[i] && hy < vs1[i]);
    end
    ft_e = pen && (cx == ht[i] - 1) && (cy == vt[i] - 1) &&
           ((n / (ht[i] * vt[i])) % fpg[i] == fpg[i] - 1);
    chk($sformatf("u%0d_pix_en@%0d", i, k), 32'(pe[i]), 32'(pen));
    chk($sformatf("u%0d_VGAx@%0d", i, k), 32'(vx[i]), 32'(cx));
    chk($sformatf("u%0d_VGAy@%0d", i, k), 32'(vy[i]), 32'(cy));
    chk($sformatf("u%0d_rgb@%0d", i, k), 32'(rgbo[i]), 32'(rgb_e));
    chk($sformatf("u%0d_hsync@%0d", i, k), 32'(hs[i]), 32'(hs_e));
    chk($sformatf("u%0d_vsync@%0d", i, k), 32'(vs[i]), 32'(vs_e));
    chk($sformatf("u%0d_video_on@%0d", i, k), 32'(von[i]), 32'(von_e));
    chk($sformatf("u%0d_frame_tick@%0d", i, k), 32'(ft[i]), 32'(ft_e));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
    for (int i = 0; i < 3; i++) model_check(i);
    if (ft[1] === 1'b1) tick_cnt++;
    if (hs[0] === 1'b0) hs_low_cnt++;
    rgb_in = 3'($urandom);
  endtask

  initial begin
    dv[0] = 2; ht[0] = 800; vt[0] = 525; hv[0] = 640; vv[0] = 480;
    hs0[0] = 656; hs1[0] = 752; vs0[0] = 490; vs1[0] = 492; fpg[0] = 30;
    for (int i = 1; i < 3; i++) begin
      ht[i] = 15; vt[i] = 10; hv[i] = 8; vv[i] = 6;
      hs0[i] = 10; hs1[i] = 13; vs0[i] = 7; vs1[i] = 9;
    end
    dv[1] = 3; fpg[1] = 3;
    dv[2] = 1; fpg[2] = 1;
    for (int i = 0; i < 3; i++) last_rgb[i] = 3'b000;

    // Power-up reset, then release between edges.
    clr        = 1'b0;
    rgb_in     = 3'b000;
    k          = 0;
    tick_cnt   = 0;
    hs_low_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    clr = 1'b1;

    // Two default lines, >7 reduced frames, ~22 frames at CLK_DIV=1.
    repeat (3400) step();
    chk("def_hsync_low_clks", 32'(hs_low_cnt), 32'd384);
    chk("sm_frame_tick_count", 32'(tick_cnt), 32'd2);

    // Mid-pixel asynchronous reset: outputs clear with no clock edge.
    #3;
    clr = 1'b0;
    #1;
    check_reset("async");
    @(posedge clk);
    #1;
    check_reset("held");

    // Release again and check counting restarts from (0,0).
    #3;
    clr = 1'b1;
    k   = 0;
    for (int i = 0; i < 3; i++) last_rgb[i] = 3'b000;
    repeat (400) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
